// File: rtl/icache_memory_controller.sv
// rtl/icache_memory_controller.sv - byte-serial load/store memory controller plus direct-mapped instruction cache
module icache_memory_controller #(
  parameter int IC_INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        mc_valid,
  input  logic        mc_wr,
  input  logic [31:0] mc_addr,
  input  logic [2:0]  mc_len,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic [31:0] mc_res,
  input  logic [31:0] ic_addr,
  output logic        ic_hit,
  output logic [31:0] ic_res,
  input  logic        ic_we,
  input  logic [31:0] ic_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_wr, w_wr_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [2:0]  r_len, w_len_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [31:0] r_res, w_res_nxt;

  logic [2:0]  w_nbytes;
  logic        w_stall;
  logic        w_issue;
  logic [31:0] w_byte_addr;
  logic [1:0]  w_cidx;

  function automatic logic [31:0] load_ext(input logic [2:0] len, input logic [31:0] b);
    case (len)
      3'b000:  load_ext = {{24{b[7]}}, b[7:0]};
      3'b001:  load_ext = {{16{b[15]}}, b[15:0]};
      3'b100:  load_ext = {24'd0, b[7:0]};
      3'b101:  load_ext = {16'd0, b[15:0]};
      default: load_ext = b;
    endcase
  endfunction

  assign w_nbytes    = (r_len[1:0] == 2'b00) ? 3'd1 : (r_len[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign w_stall     = io_buffer_full && (r_addr[17:16] == 2'b11);
  assign w_issue     = (r_state == S_BUSY) && (r_cnt < w_nbytes) && !(r_wr && w_stall);
  assign w_byte_addr = r_addr + {29'd0, r_cnt};
  // Reads capture one cycle behind the address, so byte r_cnt-1 arrives now
  assign w_cidx      = r_cnt[1:0] - 2'd1;
  assign mc_res      = r_res;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    w_res_nxt   = r_res;
    mem_a       = 32'd0;
    mem_dout    = 8'd0;
    mem_wr      = 1'b0;
    mc_ready    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mc_valid) begin
          w_wr_nxt    = mc_wr;
          w_addr_nxt  = mc_addr;
          w_len_nxt   = mc_len;
          w_data_nxt  = mc_data;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_issue) begin
          mem_a = w_byte_addr;
          if (r_wr) begin
            mem_wr   = 1'b1;
            mem_dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
          end
        end
        if (r_wr) begin
          if (w_issue) begin
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt == w_nbytes - 3'd1) w_state_nxt = S_DONE;
          end
        end else begin
          if (r_cnt != 3'd0) w_buf_nxt[{w_cidx, 3'b000} +: 8] = mem_din;
          if (r_cnt == w_nbytes) begin
            w_state_nxt = S_DONE;
            w_res_nxt   = load_ext(r_len, w_buf_nxt);
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      S_DONE: begin
        mc_ready    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rdy_in) begin
      mem_wr   = 1'b0;
      mc_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_addr  <= 32'd0;
      r_len   <= 3'd0;
      r_data  <= 32'd0;
      r_cnt   <= 3'd0;
      r_buf   <= 32'd0;
      r_res   <= 32'd0;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      r_res   <= w_res_nxt;
    end
  end

  localparam int TAG_W = 32 - IC_INDEX_BITS - 2;
  localparam int LINES = 1 << IC_INDEX_BITS;

  logic [LINES-1:0]         r_valid;
  logic [TAG_W-1:0]         r_tag  [LINES];
  logic [31:0]              r_line [LINES];
  logic [IC_INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]         w_tag;

  assign w_idx  = ic_addr[IC_INDEX_BITS+1:2];
  assign w_tag  = ic_addr[31:IC_INDEX_BITS+2];
  assign ic_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign ic_res = r_line[w_idx];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= '0;
    end else if (rdy_in && ic_we) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only visible once its valid bit is set
  always_ff @(posedge clk_in) begin
    if (rdy_in && ic_we) begin
      r_tag[w_idx]  <= w_tag;
      r_line[w_idx] <= ic_data;
    end
  end

endmodule

// File: tb/tb_icache_memory_controller.sv
// tb/tb_icache_memory_controller.sv - scoreboard bench for icache_memory_controller
module tb_icache_memory_controller;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        mc_valid, mc_wr, mc_ready;
  logic [31:0] mc_addr, mc_data, mc_res;
  logic [2:0]  mc_len;
  logic [31:0] ic_addr, ic_res, ic_data;
  logic        ic_hit, ic_we;

  icache_memory_controller #(.IC_INDEX_BITS(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_data(mc_data), .mc_ready(mc_ready), .mc_res(mc_res),
    .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_res(ic_res), .ic_we(ic_we), .ic_data(ic_data)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] res;
    int          rcyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  mdl [logic [31:0]];
  logic [31:0] last_res = 32'd0;
  int checks = 0, failures = 0;
  int cyc = 0, io_wr_cnt = 0, io_wr_cyc = 0, ready_cnt = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM: a read byte is returned the cycle after its address
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  always @(negedge clk_in) begin
    exp_t e;
    if (mem_wr && mem_a == 32'h30000) begin
      io_wr_cnt++;
      io_wr_cyc = cyc;
    end
    if (mc_ready) begin
      ready_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        check32({e.name, "_res"}, mc_res, e.res);
        check32({e.name, "_cycle"}, cyc, e.rcyc);
      end
    end
  end

  // Reference: bytes from the flat model memory, extension by arithmetic on the value
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                           input logic [31:0] data, input int stalls, input string nm);
    exp_t        e;
    int          n;
    logic [31:0] v;
    n = (len[1:0] == 2'b00) ? 1 : (len[1:0] == 2'b01) ? 2 : 4;
    if (wr) begin
      for (int i = 0; i < n; i++) mdl[addr + i] = 8'((data >> (8 * i)) & 32'hFF);
      e.rcyc = cyc + 1 + n + stalls;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v + (32'(mdl_rd(addr + i)) << (8 * i));
      if (!len[2] && n == 1 && v >= 32'h80) v = v - 32'h100;
      if (!len[2] && n == 2 && v >= 32'h8000) v = v - 32'h10000;
      last_res = v;
      e.rcyc = cyc + 2 + n;
    end
    e.res  = last_res;
    e.name = nm;
    sbq.push_back(e);
    mc_wr    = wr;
    mc_addr  = addr;
    mc_len   = len;
    mc_data  = data;
    mc_valid = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk_in); #1;
      if (mc_ready) got = 1'b1;
    end
    mc_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ready expected=ready", nm);
    end
    @(posedge clk_in); #1;
  endtask

  logic [2:0]  lens [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [31:0] pool [8] = '{32'h1000, 32'h1100, 32'h2004, 32'h3004, 32'h40, 32'h80, 32'h1040, 32'h7ffc};
  logic        mvalid [64];
  logic [29:0] mline  [64];
  logic [31:0] mdata  [64];

  initial begin
    logic [7:0]  b;
    logic [31:0] a, d;
    int          rc, idx;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    mc_valid = 1'b0; mc_wr = 1'b0; mc_addr = 32'd0; mc_len = 3'd0; mc_data = 32'd0;
    ic_addr = 32'd0; ic_we = 1'b0; ic_data = 32'd0;
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      mdl[i] = b;
    end
    ram[32'h40] = 8'h80; ram[32'h42] = 8'h01; ram[32'h43] = 8'h80;
    mdl[32'h40] = 8'h80; mdl[32'h42] = 8'h01; mdl[32'h43] = 8'h80;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    mdl[32'h1000] = 8'h13; mdl[32'h1001] = 8'h05; mdl[32'h1002] = 8'h00; mdl[32'h1003] = 8'h00;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    repeat (5) @(posedge clk_in);
    #1;
    check32("rst_mc_ready", 32'(mc_ready), 32'd0);
    check32("rst_mem_wr", 32'(mem_wr), 32'd0);
    check32("rst_mem_a", mem_a, 32'd0);
    check32("rst_mem_dout", 32'(mem_dout), 32'd0);
    check32("rst_mc_res", mc_res, 32'd0);
    check32("rst_ic_hit_0", 32'(ic_hit), 32'd0);
    ic_addr = 32'h1000; #1;
    check32("rst_ic_hit_1000", 32'(ic_hit), 32'd0);

    start_req(1'b0, 32'h1000, 3'b010, 32'd0, 0, "lw_1000");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      check32("lw_mem_a", mem_a, 32'h1000 + 32'(i));
      check32("lw_mem_wr", 32'(mem_wr), 32'd0);
    end
    wait_done("lw_1000");
    check32("lw_value", mc_res, 32'h00000513);

    start_req(1'b0, 32'h40, 3'b000, 32'd0, 0, "lb_neg");
    wait_done("lb_neg");
    check32("lb_neg_value", mc_res, 32'hFFFFFF80);
    start_req(1'b0, 32'h40, 3'b100, 32'd0, 0, "lbu");
    wait_done("lbu");
    check32("lbu_value", mc_res, 32'h00000080);
    start_req(1'b0, 32'h42, 3'b001, 32'd0, 0, "lh_neg");
    wait_done("lh_neg");
    check32("lh_neg_value", mc_res, 32'hFFFF8001);

    start_req(1'b1, 32'h20, 3'b001, 32'h0000BEEF, 0, "sh_20");
    @(posedge clk_in); #1;
    check32("sh_a0", mem_a, 32'h20);
    check32("sh_d0", 32'(mem_dout), 32'hEF);
    check32("sh_w0", 32'(mem_wr), 32'd1);
    @(posedge clk_in); #1;
    check32("sh_a1", mem_a, 32'h21);
    check32("sh_d1", 32'(mem_dout), 32'hBE);
    check32("sh_w1", 32'(mem_wr), 32'd1);
    wait_done("sh_20");
    check32("sh_res_unchanged", mc_res, 32'hFFFF8001);

    io_wr_cnt = 0;
    io_buffer_full = 1'b1;
    start_req(1'b1, 32'h30000, 3'b000, 32'h000000A5, 3, "io_sb");
    rc = cyc;
    repeat (4) @(posedge clk_in);
    #1 io_buffer_full = 1'b0;
    wait_done("io_sb");
    check32("io_wr_count", 32'(io_wr_cnt), 32'd1);
    check32("io_wr_cycle", 32'(io_wr_cyc), 32'(rc + 4));

    io_wr_cnt = 0;
    rc = ready_cnt;
    io_buffer_full = 1'b1;
    mc_wr = 1'b1; mc_addr = 32'h30000; mc_len = 3'b000; mc_data = 32'h5A; mc_valid = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    mc_valid = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    io_buffer_full = 1'b0;
    last_res = 32'd0;
    repeat (6) @(posedge clk_in);
    #1;
    check32("abort_wr_count", 32'(io_wr_cnt), 32'd0);
    check32("abort_ready_count", 32'(ready_cnt - rc), 32'd0);

    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 255));
      d = $urandom;
      start_req(1'($urandom_range(0, 1)), a, lens[$urandom_range(0, 4)], d, 0, "rnd");
      wait_done("rnd");
      repeat ($urandom_range(0, 2)) @(posedge clk_in);
      #1;
    end
    check32("sb_empty", 32'(sbq.size()), 32'd0);

    ic_addr = 32'h1000; ic_data = 32'h00000513; ic_we = 1'b1;
    @(posedge clk_in); #1 ic_we = 1'b0; #1;
    check32("ic_hit_1000", 32'(ic_hit), 32'd1);
    check32("ic_res_1000", ic_res, 32'h00000513);
    ic_addr = 32'h1003; #1;
    check32("ic_hit_lowbits", 32'(ic_hit), 32'd1);
    ic_addr = 32'h1100; #1;
    check32("ic_miss_1100", 32'(ic_hit), 32'd0);
    ic_data = 32'hCAFE0001; ic_we = 1'b1;
    @(posedge clk_in); #1 ic_we = 1'b0; #1;
    check32("ic_hit_1100", 32'(ic_hit), 32'd1);
    ic_addr = 32'h1000; #1;
    check32("ic_evicted_1000", 32'(ic_hit), 32'd0);
    mvalid[0] = 1'b1; mline[0] = 30'(32'h1100 >> 2); mdata[0] = 32'hCAFE0001;

    for (int t = 0; t < 40; t++) begin
      a = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
      idx = int'((a >> 2) % 64);
      ic_addr = a;
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        ic_data = d; ic_we = 1'b1;
        @(posedge clk_in); #1 ic_we = 1'b0;
        mvalid[idx] = 1'b1; mline[idx] = 30'(a >> 2); mdata[idx] = d;
      end else begin
        #1;
        check32("ic_rnd_hit", 32'(ic_hit), 32'(mvalid[idx] && mline[idx] == 30'(a >> 2)));
        if (mvalid[idx] && mline[idx] == 30'(a >> 2)) check32("ic_rnd_res", ic_res, mdata[idx]);
        @(posedge clk_in); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/icache_memory_controller.md
Name: icache_memory_controller

Overview:
- Instruction-side cache plus byte-serial memory controller for the RV32I CPU front end. Two independent sub-functions share one clock and reset.
- Memory controller (mc_*): turns 1/2/4-byte load/store requests into one-byte-per-cycle RAM/IO bus transactions.
- Instruction cache (ic_*): direct-mapped, one 32-bit word per line. Filled from the controller's read result.
- The surrounding cache arbiter holds mc_valid until mc_ready, and raises ic_we when a fetch refill completes.

Parameters:
- IC_INDEX_BITS, 6, log2 of instruction-cache line count (64 lines).

Ports:
- clk_in  in  1  clock, all state on rising edge
- rst_in  in  1  asynchronous active-high reset (the arbiter ORs in pipeline flush to abort the controller)
- rdy_in  in  1  global enable; low freezes all state
- mem_din  in  8  RAM/IO read byte, valid the cycle after its address
- mem_dout  out  8  RAM/IO write byte
- mem_a  out  32  RAM/IO byte address
- mem_wr  out  1  1 = write cycle
- io_buffer_full  in  1  IO output buffer full
- mc_valid  in  1  request valid, held until mc_ready
- mc_wr  in  1  1 = store, 0 = load
- mc_addr  in  32  byte address
- mc_len  in  3  RISC-V funct3 size: [1:0] 00=1B, 01=2B, 10=4B; [2]=1 zero-extend loads
- mc_data  in  32  store data, little-endian
- mc_ready  out  1  one-cycle completion pulse
- mc_res  out  32  load result; also the icache refill data
- ic_addr  in  32  fetch PC
- ic_hit  out  1  combinational hit
- ic_res  out  32  combinational cached word
- ic_we  in  1  refill strobe
- ic_data  in  32  refill word

Behaviour:
- Reset (async):
  - controller to IDLE; mem_a=0, mem_dout=0, mem_wr=0, mc_ready=0, mc_res=0
  - all icache valid bits cleared
  - reset mid-transaction aborts it: no mc_ready, no further mem_wr
- rdy_in=0: no state change; mem_wr forced 0.
- Controller state machine: IDLE, BUSY, DONE.
  - IDLE, mc_valid sampled high at edge E0: latch wr/addr/len/data, set byte counter = 0, go BUSY. The first bus cycle is the cycle after E0 (cycle A).
  - BUSY write, n bytes: cycles A..A+n-1 drive mem_a=addr+i, mem_dout=byte i (data[8i+7:8i]), mem_wr=1.
  - IO write stall: if io_buffer_full=1 and addr[17:16]==2'b11 (0x30000+), the cycle issues nothing (mem_wr=0) and the counter holds.
  - After the last byte, go DONE; mc_ready=1 in cycle A+n.
  - BUSY read: cycles A..A+n-1 drive mem_a=addr+i, mem_wr=0. The byte on mem_din in cycle A+i+1 is stored into result bits [8i+7:8i].
  - After the last byte is captured, go DONE; mc_ready=1 in cycle A+n+1.
- Load extension:
  - len[2]=0: 1B/2B results sign-extended from bit 7/15
  - len[2]=1: zero-extended
  - stores return mc_res unchanged
- DONE: mc_ready=1 for exactly one cycle, mc_res valid, then IDLE unconditionally. mc_valid on the DONE-exit edge is ignored.
- mc_res holds its value until the next load completes.
- Outside write cycles: mem_wr=0 and mem_dout=0. In IDLE and DONE: mem_a=0.
- Icache address split:
  - index = ic_addr[IC_INDEX_BITS+1:2]
  - tag = ic_addr[31:IC_INDEX_BITS+2]
  - ic_addr[1:0] ignored
- Icache read: ic_hit = valid[index] && tag match. ic_res = data[index] (don't-care when miss).
- Icache write: on an edge with ic_we=1, line[index(ic_addr)] gets ic_data, its tag is stored and valid is set. ic_hit rises the next cycle.
  - A conflicting address overwrites the line (no associativity).
  - No write-back; stores never update the icache.

Test Plan:
- Reset, then idle 5 cycles -> mc_ready=0, mem_wr=0, mem_a=0; ic_hit=0 for ic_addr=0 and 0x1000.
- Word load addr=0x1000, len=010, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a=0x1000..0x1003 on consecutive cycles; mc_ready in cycle A+5; mc_res=0x00000513.
- Byte load of 0x80 -> len=000 gives 0xFFFFFF80; len=100 gives 0x00000080. Half load of 0x8001 with len=001 -> 0xFFFF8001.
- Half store 0xBEEF to 0x20 -> cycle A: mem_a=0x20, dout=0xEF, wr=1; A+1: mem_a=0x21, dout=0xBE, wr=1; mc_ready in A+2.
- Byte store to 0x30000 with io_buffer_full high 3 cycles -> no mem_wr for those cycles, then a single write; mc_ready the following cycle.
- Byte store to 0x30000 with io_buffer_full high -> assert rst_in mid-stall -> no mc_ready, mem_wr stays 0.
- Icache: ic_we with ic_addr=0x1000, data 0x00000513 -> next cycle ic_hit=1, ic_res=0x00000513.
- Icache conflict: ic_addr=0x1100 -> ic_hit=0; refill 0x1100 -> 0x1000 now misses.
